gray_counter: RTL and testbench

Parametrised up/down counter that keeps its state in binary and also drives a registered Gray-code copy of that state, plus the combinational Gray value for the next cycle. It is the sequential successor to the combinational binary-to-Gray converter. It is the pointer primitive for async FIFOs and other clock-domain-crossing structures, where a flop-driven, single-bit-change Gray bus is required. It also adds load (binary or Gray-coded), direction control, saturate/wrap mode and boundary flags.

---
 rtl/gray_counter_if.sv | 26 ++
 rtl/gray_counter.sv | 85 ++++++++
 tb/tb_gray_counter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/gray_counter_if.sv
// Control and status bundle for gray_counter: count/load strobes in, binary/Gray state and flags out.
interface gray_counter_if #(
  parameter int unsigned WIDTH = 8
);
  logic             en_i;
  logic             up_i;
  logic             load_i;
  logic             load_gray_i;
  logic [WIDTH-1:0] load_val_i;
  logic [WIDTH-1:0] bin_o;
  logic [WIDTH-1:0] gray_o;
  logic [WIDTH-1:0] gray_next_o;
  logic             wrap_o;
  logic             at_max_o;
  logic             at_min_o;

  modport master (
    output en_i, up_i, load_i, load_gray_i, load_val_i,
    input  bin_o, gray_o, gray_next_o, wrap_o, at_max_o, at_min_o
  );

  modport slave (
    input  en_i, up_i, load_i, load_gray_i, load_val_i,
    output bin_o, gray_o, gray_next_o, wrap_o, at_max_o, at_min_o
  );
endinterface

// File: rtl/gray_counter.sv
// Up/down binary counter with a flop-driven Gray copy, binary or Gray load, and wrap/saturate limits.
// The Gray register is fed from the next binary value so its output is glitch-free for CDC use.
module gray_counter #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned RESET_VAL = 0,
  parameter bit          SATURATE  = 1'b0
) (
  input logic          clk_i,
  input logic          rst_i,
  gray_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;
  localparam logic [WIDTH-1:0] MIN_VAL = '0;
  localparam logic [WIDTH-1:0] RST_BIN = WIDTH'(RESET_VAL);

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at and above it.
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] gray_q;
  logic             wrap_q;
  logic [WIDTH-1:0] bin_d;
  logic [WIDTH-1:0] gray_d;
  logic             wrap_d;

  // Next-value select: reset > load > count > hold.
  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    if (rst_i) begin
      bin_d = RST_BIN;
    end else if (bus.load_i) begin
      bin_d = bus.load_gray_i ? gray2bin(bus.load_val_i) : bus.load_val_i;
    end else if (bus.en_i) begin
      if (bus.up_i) begin
        if (bin_q != MAX_VAL) begin
          bin_d = bin_q + 1'b1;
        end else if (!SATURATE) begin
          bin_d  = MIN_VAL;
          wrap_d = 1'b1;
        end
      end else begin
        if (bin_q != MIN_VAL) begin
          bin_d = bin_q - 1'b1;
        end else if (!SATURATE) begin
          bin_d  = MAX_VAL;
          wrap_d = 1'b1;
        end
      end
    end
    gray_d = bin2gray(bin_d);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bin_q  <= RST_BIN;
      gray_q <= bin2gray(RST_BIN);
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.bin_o       = bin_q;
  assign bus.gray_o      = gray_q;
  assign bus.gray_next_o = gray_d;
  assign bus.wrap_o      = wrap_q;
  assign bus.at_max_o    = (bin_q == MAX_VAL);
  assign bus.at_min_o    = (bin_q == MIN_VAL);

endmodule

// File: tb/tb_gray_counter.sv
// Directed checks of gray_counter across four parameter sets plus a model-checked random run at WIDTH=8.
module tb_gray_counter;

  logic clk;
  logic rst_a, rst_s, rst_p, rst_r;
  int   n_cmp;
  int   n_bad;
  logic [3:0] up_seq [16];

  gray_counter_if #(.WIDTH(4)) b_a ();
  gray_counter_if #(.WIDTH(4)) b_s ();
  gray_counter_if #(.WIDTH(4)) b_p ();
  gray_counter_if #(.WIDTH(8)) b_r ();

  gray_counter #(.WIDTH(4), .RESET_VAL(0), .SATURATE(1'b0)) u_a (.clk_i(clk), .rst_i(rst_a), .bus(b_a));
  gray_counter #(.WIDTH(4), .RESET_VAL(0), .SATURATE(1'b1)) u_s (.clk_i(clk), .rst_i(rst_s), .bus(b_s));
  gray_counter #(.WIDTH(4), .RESET_VAL(5), .SATURATE(1'b0)) u_p (.clk_i(clk), .rst_i(rst_p), .bus(b_p));
  gray_counter #(.WIDTH(8), .RESET_VAL(0), .SATURATE(1'b0)) u_r (.clk_i(clk), .rst_i(rst_r), .bus(b_r));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] m_b2g(input logic [7:0] b);
    return b ^ {1'b0, b[7:1]};
  endfunction

  function automatic logic [7:0] m_g2b(input logic [7:0] g);
    logic [7:0] b;
    b[7] = g[7];
    for (int i = 6; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_s = 1'b1; rst_p = 1'b1; rst_r = 1'b1;
    #1;
    n_cmp++; if (b_p.gray_next_o !== 4'h7) begin n_bad++; $display("FAIL rst_p_gray_next: got %h want 7", b_p.gray_next_o); end
    tick();
    tick();
    n_cmp++; if (b_a.bin_o !== 4'h0)  begin n_bad++; $display("FAIL rst_a_bin: got %h want 0", b_a.bin_o); end
    n_cmp++; if (b_a.gray_o !== 4'h0) begin n_bad++; $display("FAIL rst_a_gray: got %h want 0", b_a.gray_o); end
    n_cmp++; if (b_a.wrap_o !== 1'b0) begin n_bad++; $display("FAIL rst_a_wrap: got %b want 0", b_a.wrap_o); end
    n_cmp++; if (b_a.at_min_o !== 1'b1 || b_a.at_max_o !== 1'b0)
      begin n_bad++; $display("FAIL rst_a_flags: got min=%b max=%b want min=1 max=0", b_a.at_min_o, b_a.at_max_o); end
    n_cmp++; if (b_p.bin_o !== 4'h5)  begin n_bad++; $display("FAIL rst_p_bin: got %h want 5", b_p.bin_o); end
    n_cmp++; if (b_p.gray_o !== 4'h7) begin n_bad++; $display("FAIL rst_p_gray: got %h want 7", b_p.gray_o); end
    n_cmp++; if (b_p.at_min_o !== 1'b0 || b_p.at_max_o !== 1'b0)
      begin n_bad++; $display("FAIL rst_p_flags: got min=%b max=%b want min=0 max=0", b_p.at_min_o, b_p.at_max_o); end
    n_cmp++; if (b_r.bin_o !== 8'h00) begin n_bad++; $display("FAIL rst_r_bin: got %h want 00", b_r.bin_o); end
    rst_a = 1'b0; rst_s = 1'b0; rst_p = 1'b0; rst_r = 1'b0;
  endtask

  task automatic test_count_up();
    logic [3:0] prev;
    up_seq = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
               4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
    prev = b_a.gray_o;
    for (int i = 0; i < 16; i++) begin
      b_a.en_i = 1'b1; b_a.up_i = 1'b1;
      #1;
      n_cmp++; if (b_a.gray_next_o !== up_seq[i])
        begin n_bad++; $display("FAIL up_gray_next[%0d]: got %h want %h", i, b_a.gray_next_o, up_seq[i]); end
      tick();
      n_cmp++; if (b_a.gray_o !== up_seq[i])
        begin n_bad++; $display("FAIL up_gray[%0d]: got %h want %h", i, b_a.gray_o, up_seq[i]); end
      n_cmp++; if (b_a.bin_o !== 4'(i + 1))
        begin n_bad++; $display("FAIL up_bin[%0d]: got %h want %h", i, b_a.bin_o, 4'(i + 1)); end
      n_cmp++; if (b_a.wrap_o !== (i == 15))
        begin n_bad++; $display("FAIL up_wrap[%0d]: got %b want %b", i, b_a.wrap_o, (i == 15)); end
      n_cmp++; if ($countones(prev ^ b_a.gray_o) !== 1)
        begin n_bad++; $display("FAIL up_hamming[%0d]: got %0d bits want 1", i, $countones(prev ^ b_a.gray_o)); end
      prev = b_a.gray_o;
    end
    b_a.en_i = 1'b0;
  endtask

  task automatic test_count_down();
    b_a.en_i = 1'b1; b_a.up_i = 1'b0;
    tick();
    n_cmp++; if (b_a.bin_o !== 4'hF)  begin n_bad++; $display("FAIL down_wrap_bin: got %h want F", b_a.bin_o); end
    n_cmp++; if (b_a.gray_o !== 4'h8) begin n_bad++; $display("FAIL down_wrap_gray: got %h want 8", b_a.gray_o); end
    n_cmp++; if (b_a.wrap_o !== 1'b1) begin n_bad++; $display("FAIL down_wrap_pulse: got %b want 1", b_a.wrap_o); end
    n_cmp++; if (b_a.at_max_o !== 1'b1) begin n_bad++; $display("FAIL down_at_max: got %b want 1", b_a.at_max_o); end
    tick();
    n_cmp++; if (b_a.bin_o !== 4'hE)  begin n_bad++; $display("FAIL down_bin: got %h want E", b_a.bin_o); end
    n_cmp++; if (b_a.gray_o !== 4'h9) begin n_bad++; $display("FAIL down_gray: got %h want 9", b_a.gray_o); end
    n_cmp++; if (b_a.wrap_o !== 1'b0) begin n_bad++; $display("FAIL down_wrap_clear: got %b want 0", b_a.wrap_o); end
    b_a.en_i = 1'b0;
    tick();
    n_cmp++; if (b_a.bin_o !== 4'hE)  begin n_bad++; $display("FAIL hold_bin: got %h want E", b_a.bin_o); end
  endtask

  task automatic test_gray_load();
    b_a.load_i = 1'b1; b_a.load_gray_i = 1'b1; b_a.load_val_i = 4'hB;
    #1;
    n_cmp++; if (b_a.gray_next_o !== 4'hB) begin n_bad++; $display("FAIL gload_gray_next: got %h want B", b_a.gray_next_o); end
    tick();
    n_cmp++; if (b_a.bin_o !== 4'hD)  begin n_bad++; $display("FAIL gload_bin: got %h want D", b_a.bin_o); end
    n_cmp++; if (b_a.gray_o !== 4'hB) begin n_bad++; $display("FAIL gload_gray: got %h want B", b_a.gray_o); end
    n_cmp++; if (b_a.wrap_o !== 1'b0) begin n_bad++; $display("FAIL gload_wrap: got %b want 0", b_a.wrap_o); end
    b_a.load_gray_i = 1'b0;
    tick();
    n_cmp++; if (b_a.bin_o !== 4'hB)  begin n_bad++; $display("FAIL bload_bin: got %h want B", b_a.bin_o); end
    n_cmp++; if (b_a.gray_o !== 4'hE) begin n_bad++; $display("FAIL bload_gray: got %h want E", b_a.gray_o); end
    // Load F then load 0 with an up-enable present: crossing the limit by load is not a wrap.
    b_a.load_val_i = 4'hF;
    tick();
    b_a.load_val_i = 4'h0; b_a.en_i = 1'b1; b_a.up_i = 1'b1;
    tick();
    n_cmp++; if (b_a.bin_o !== 4'h0)  begin n_bad++; $display("FAIL load_cross_bin: got %h want 0", b_a.bin_o); end
    n_cmp++; if (b_a.wrap_o !== 1'b0) begin n_bad++; $display("FAIL load_cross_wrap: got %b want 0", b_a.wrap_o); end
    b_a.load_i = 1'b0; b_a.en_i = 1'b0;
  endtask

  task automatic test_saturate();
    b_s.load_i = 1'b1; b_s.load_gray_i = 1'b0; b_s.load_val_i = 4'hF;
    tick();
    b_s.load_i = 1'b0; b_s.en_i = 1'b1; b_s.up_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (b_s.gray_next_o !== 4'h8) begin n_bad++; $display("FAIL sat_up_gray_next[%0d]: got %h want 8", i, b_s.gray_next_o); end
      tick();
      n_cmp++; if (b_s.bin_o !== 4'hF)    begin n_bad++; $display("FAIL sat_up_bin[%0d]: got %h want F", i, b_s.bin_o); end
      n_cmp++; if (b_s.at_max_o !== 1'b1) begin n_bad++; $display("FAIL sat_up_at_max[%0d]: got %b want 1", i, b_s.at_max_o); end
      n_cmp++; if (b_s.wrap_o !== 1'b0)   begin n_bad++; $display("FAIL sat_up_wrap[%0d]: got %b want 0", i, b_s.wrap_o); end
    end
    b_s.en_i = 1'b0; b_s.load_i = 1'b1; b_s.load_val_i = 4'h0;
    tick();
    b_s.load_i = 1'b0; b_s.en_i = 1'b1; b_s.up_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (b_s.bin_o !== 4'h0)    begin n_bad++; $display("FAIL sat_dn_bin[%0d]: got %h want 0", i, b_s.bin_o); end
      n_cmp++; if (b_s.at_min_o !== 1'b1) begin n_bad++; $display("FAIL sat_dn_at_min[%0d]: got %b want 1", i, b_s.at_min_o); end
      n_cmp++; if (b_s.wrap_o !== 1'b0)   begin n_bad++; $display("FAIL sat_dn_wrap[%0d]: got %b want 0", i, b_s.wrap_o); end
    end
    b_s.en_i = 1'b0;
  endtask

  task automatic test_priority();
    b_p.en_i = 1'b1; b_p.up_i = 1'b1;
    tick(); tick(); tick();
    n_cmp++; if (b_p.bin_o !== 4'h8) begin n_bad++; $display("FAIL pri_count_bin: got %h want 8", b_p.bin_o); end
    rst_p = 1'b1; b_p.load_i = 1'b1; b_p.load_gray_i = 1'b0; b_p.load_val_i = 4'hA;
    #1;
    n_cmp++; if (b_p.gray_next_o !== 4'h7) begin n_bad++; $display("FAIL pri_rst_gray_next: got %h want 7", b_p.gray_next_o); end
    tick();
    n_cmp++; if (b_p.bin_o !== 4'h5)  begin n_bad++; $display("FAIL pri_rst_bin: got %h want 5", b_p.bin_o); end
    n_cmp++; if (b_p.gray_o !== 4'h7) begin n_bad++; $display("FAIL pri_rst_gray: got %h want 7", b_p.gray_o); end
    rst_p = 1'b0; b_p.load_val_i = 4'h3;
    tick();
    n_cmp++; if (b_p.bin_o !== 4'h3)  begin n_bad++; $display("FAIL pri_load_bin: got %h want 3", b_p.bin_o); end
    n_cmp++; if (b_p.gray_o !== 4'h2) begin n_bad++; $display("FAIL pri_load_gray: got %h want 2", b_p.gray_o); end
    b_p.load_i = 1'b0;
    tick();
    n_cmp++; if (b_p.bin_o !== 4'h4)  begin n_bad++; $display("FAIL pri_resume_bin: got %h want 4", b_p.bin_o); end
    b_p.en_i = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] m, nxt;
    logic       nw, r, ld, lg, en, up;
    logic [7:0] val;
    m = 8'h00;
    for (int c = 0; c < 10000; c++) begin
      r   = ($urandom_range(0, 63) == 0);
      ld  = ($urandom_range(0, 7) == 0);
      lg  = 1'($urandom_range(0, 1));
      en  = ($urandom_range(0, 3) != 0);
      up  = 1'($urandom_range(0, 1));
      val = 8'($urandom_range(0, 255));
      rst_r = r; b_r.load_i = ld; b_r.load_gray_i = lg; b_r.en_i = en; b_r.up_i = up; b_r.load_val_i = val;
      nw = 1'b0;
      if (r)       nxt = 8'h00;
      else if (ld) nxt = lg ? m_g2b(val) : val;
      else if (en) begin
        nxt = up ? m + 8'd1 : m - 8'd1;
        nw  = up ? (m == 8'hFF) : (m == 8'h00);
      end else     nxt = m;
      #1;
      n_cmp++; if (b_r.gray_next_o !== m_b2g(nxt))
        begin n_bad++; $display("FAIL rnd_gray_next[%0d]: got %h want %h", c, b_r.gray_next_o, m_b2g(nxt)); end
      tick();
      m = nxt;
      n_cmp++; if (b_r.bin_o !== m)
        begin n_bad++; $display("FAIL rnd_bin[%0d]: got %h want %h", c, b_r.bin_o, m); end
      n_cmp++; if (b_r.gray_o !== m_b2g(m))
        begin n_bad++; $display("FAIL rnd_gray[%0d]: got %h want %h", c, b_r.gray_o, m_b2g(m)); end
      n_cmp++; if (b_r.wrap_o !== nw)
        begin n_bad++; $display("FAIL rnd_wrap[%0d]: got %b want %b", c, b_r.wrap_o, nw); end
      n_cmp++; if (b_r.at_max_o !== (m == 8'hFF) || b_r.at_min_o !== (m == 8'h00))
        begin n_bad++; $display("FAIL rnd_flags[%0d]: got max=%b min=%b for bin %h", c, b_r.at_max_o, b_r.at_min_o, m); end
      if (n_bad > 20) break;
    end
    rst_r = 1'b0; b_r.load_i = 1'b0; b_r.en_i = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_a = 1'b1; rst_s = 1'b1; rst_p = 1'b1; rst_r = 1'b1;
    b_a.en_i = 1'b0; b_a.up_i = 1'b0; b_a.load_i = 1'b0; b_a.load_gray_i = 1'b0; b_a.load_val_i = '0;
    b_s.en_i = 1'b0; b_s.up_i = 1'b0; b_s.load_i = 1'b0; b_s.load_gray_i = 1'b0; b_s.load_val_i = '0;
    b_p.en_i = 1'b0; b_p.up_i = 1'b0; b_p.load_i = 1'b0; b_p.load_gray_i = 1'b0; b_p.load_val_i = '0;
    b_r.en_i = 1'b0; b_r.up_i = 1'b0; b_r.load_i = 1'b0; b_r.load_gray_i = 1'b0; b_r.load_val_i = '0;
    test_reset();
    test_count_up();
    test_count_down();
    test_gray_load();
    test_saturate();
    test_priority();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
